// File: rtl/thermostat_hvac_ctrl.sv
// Thermostat HVAC controller: hysteresis, mode select, compressor min on/off protection.
// Optional fan post-run in LOCKOUT when FAN_OVERRUN_EN is defined.
module thermostat_hvac_ctrl #(
  parameter int unsigned TEMP_W      = 8,
  parameter int unsigned HYST        = 2,
  parameter int unsigned MIN_ON      = 16,
  parameter int unsigned MIN_OFF     = 16,
  parameter int unsigned FAN_OVERRUN = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick_en,
  input  logic [1:0]        mode,
  input  logic [TEMP_W-1:0] user_temp_setting,
  input  logic [TEMP_W-1:0] indoor_temp,
  output logic              heating,
  output logic              cooling,
  output logic              fan,
  output logic [1:0]        state
);

  localparam int unsigned XW    = TEMP_W + 2;
  localparam int unsigned T_MX1 = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
  localparam int unsigned T_MAX = (T_MX1 > FAN_OVERRUN) ? T_MX1 : FAN_OVERRUN;
  localparam int unsigned TW    = (T_MAX > 0) ? $clog2(T_MAX + 1) : 1;

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_HEAT = 2'b01;
  localparam logic [1:0] S_COOL = 2'b10;
  localparam logic [1:0] S_LOCK = 2'b11;

  localparam logic [1:0] M_OFF  = 2'b00;
  localparam logic [1:0] M_HEAT = 2'b01;
  localparam logic [1:0] M_COOL = 2'b10;
  localparam logic [1:0] M_AUTO = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          heating_q, heating_d;
  logic          cooling_q, cooling_d;
  logic          fan_q, fan_d;

  logic [XW-1:0] ind_x, set_x, hyst_x;
  logic          heat_dem, cool_dem, heat_sat, cool_sat;
  logic          heat_ok, cool_ok, on_done, off_done;

  // Widened operands so setpoint +/- HYST can never wrap
  always_comb begin
    ind_x    = XW'(indoor_temp);
    set_x    = XW'(user_temp_setting);
    hyst_x   = XW'(HYST);
    heat_dem = (ind_x + hyst_x) < set_x;
    cool_dem = ind_x > (set_x + hyst_x);
    heat_sat = ind_x >= set_x;
    cool_sat = ind_x <= set_x;
    heat_ok  = (mode == M_HEAT) || (mode == M_AUTO);
    cool_ok  = (mode == M_COOL) || (mode == M_AUTO);
    on_done  = timer_q >= TW'(MIN_ON);
    off_done = timer_q >= TW'(MIN_OFF);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (heat_ok && heat_dem) begin
          state_d = S_HEAT;
        end else if (cool_ok && cool_dem) begin
          state_d = S_COOL;
        end
      end
      S_HEAT: begin
        if (mode == M_OFF) begin
          state_d = S_LOCK;
        end else if ((heat_sat || (mode == M_COOL)) && on_done) begin
          state_d = S_LOCK;
        end
      end
      S_COOL: begin
        if (mode == M_OFF) begin
          state_d = S_LOCK;
        end else if ((cool_sat || (mode == M_HEAT)) && on_done) begin
          state_d = S_LOCK;
        end
      end
      default: begin
        if (off_done) begin
          state_d = S_IDLE;
        end
      end
    endcase

    // Timer restarts on every state entry and saturates at the largest threshold
    timer_d = timer_q;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (tick_en && (timer_q != TW'(T_MAX))) begin
      timer_d = timer_q + TW'(1);
    end

    heating_d = (state_d == S_HEAT);
    cooling_d = (state_d == S_COOL);
`ifdef FAN_OVERRUN_EN
    fan_d = heating_d | cooling_d |
            ((state_d == S_LOCK) && (timer_d < TW'(FAN_OVERRUN)));
`else
    fan_d = heating_d | cooling_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      heating_q <= 1'b0;
      cooling_q <= 1'b0;
      fan_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      heating_q <= heating_d;
      cooling_q <= cooling_d;
      fan_q     <= fan_d;
    end
  end

  assign heating = heating_q;
  assign cooling = cooling_q;
  assign fan     = fan_q;
  assign state   = state_q;

endmodule

// File: tb/tb_thermostat_hvac_ctrl.sv
// Bench for thermostat_hvac_ctrl: directed plan scenarios plus randomized traffic vs. a rule-level model.
module tb_thermostat_hvac_ctrl;

  localparam int HYST        = 2;
  localparam int MIN_ON      = 4;
  localparam int MIN_OFF     = 3;
  localparam int FAN_OVERRUN = 2;

  localparam int ST_IDLE = 0;
  localparam int ST_HEAT = 1;
  localparam int ST_COOL = 2;
  localparam int ST_LOCK = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_en;
  logic [1:0] mode;
  logic [7:0] user_temp_setting;
  logic [7:0] indoor_temp;
  logic       heating, cooling, fan;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;

  // Reference model: phase plus unsaturated count of ticks seen in the phase
  int m_phase = ST_IDLE;
  int m_ticks = 0;
  int m_heat  = 0;
  int m_cool  = 0;
  int m_fan   = 0;

  always #5 clk = ~clk;

  thermostat_hvac_ctrl #(
    .TEMP_W(8), .HYST(HYST), .MIN_ON(MIN_ON), .MIN_OFF(MIN_OFF), .FAN_OVERRUN(FAN_OVERRUN)
  ) dut (
    .clk(clk), .reset(reset), .tick_en(tick_en), .mode(mode),
    .user_temp_setting(user_temp_setting), .indoor_temp(indoor_temp),
    .heating(heating), .cooling(cooling), .fan(fan), .state(state)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int nxt;
    int t, s, md;
    bit want_heat, want_cool, hot_enough, cold_enough;
    if (!reset) begin
      m_phase = ST_IDLE; m_ticks = 0; m_heat = 0; m_cool = 0; m_fan = 0;
      return;
    end
    t  = int'(indoor_temp);
    s  = int'(user_temp_setting);
    md = int'(mode);
    want_heat   = (t + HYST) < s;
    want_cool   = t > (s + HYST);
    hot_enough  = t >= s;
    cold_enough = t <= s;
    nxt = m_phase;
    if (m_phase == ST_IDLE) begin
      if ((md == 1 || md == 3) && want_heat) nxt = ST_HEAT;
      else if ((md == 2 || md == 3) && want_cool) nxt = ST_COOL;
    end else if (m_phase == ST_HEAT) begin
      if (md == 0 || ((hot_enough || md == 2) && m_ticks >= MIN_ON)) nxt = ST_LOCK;
    end else if (m_phase == ST_COOL) begin
      if (md == 0 || ((cold_enough || md == 1) && m_ticks >= MIN_ON)) nxt = ST_LOCK;
    end else begin
      if (m_ticks >= MIN_OFF) nxt = ST_IDLE;
    end
    m_ticks = (nxt != m_phase) ? 0 : m_ticks + int'(tick_en);
    m_phase = nxt;
    m_heat  = (m_phase == ST_HEAT) ? 1 : 0;
    m_cool  = (m_phase == ST_COOL) ? 1 : 0;
    m_fan   = m_heat | m_cool;
`ifdef FAN_OVERRUN_EN
    if (m_phase == ST_LOCK && m_ticks < FAN_OVERRUN) m_fan = 1;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("state", int'(state), m_phase);
    check("heating", int'(heating), m_heat);
    check("cooling", int'(cooling), m_cool);
    check("fan", int'(fan), m_fan);
    check("exclusive", int'(heating & cooling), 0);
  endtask

  task automatic drive(input int rst, input int tk, input int md, input int sp, input int ind);
    reset = rst[0]; tick_en = tk[0]; mode = md[1:0];
    user_temp_setting = 8'(sp); indoor_temp = 8'(ind);
    step();
  endtask

  task automatic wait_state(input string tag, input int target, input int budget);
    int n = 0;
    while (int'(state) != target && n < budget) begin
      step();
      n++;
    end
    check(tag, int'(state), target);
  endtask

  task automatic do_reset();
    drive(0, 0, 3, 70, 70);
    drive(0, 0, 3, 70, 70);
  endtask

  initial begin
    reset = 1'b0; tick_en = 1'b0; mode = 2'b11;
    user_temp_setting = 8'd70; indoor_temp = 8'd60;

    // Reset hold, then first demand one clk after release
    drive(0, 1, 3, 70, 60);
    drive(0, 1, 3, 70, 60);
    check("rst_heating", int'(heating), 0);
    check("rst_state", int'(state), ST_IDLE);
    drive(1, 0, 3, 70, 60);
    check("release_heat", int'(heating), 1);

    // Normal heat cycle through LOCKOUT back to IDLE
    do_reset();
    drive(1, 0, 3, 70, 67);
    check("heat_entry", int'(state), ST_HEAT);
    drive(1, 1, 3, 70, 69);
    check("heat_hold", int'(heating), 1);
    for (int i = 0; i < 4; i++) drive(1, 1, 3, 70, 70);
    wait_state("heat_to_lock", ST_LOCK, 4);
    for (int i = 0; i < 4; i++) drive(1, 1, 3, 70, 70);
    check("lock_to_idle", int'(state), ST_IDLE);

    // Minimum on-time then reversal via LOCKOUT
    do_reset();
    drive(1, 0, 3, 70, 60);
    drive(1, 1, 3, 70, 75);
    check("minon_hold", int'(heating), 1);
    for (int i = 0; i < 3; i++) drive(1, 1, 3, 70, 75);
    check("minon_still", int'(heating), 1);
    drive(1, 0, 3, 70, 75);
    check("minon_lock", int'(state), ST_LOCK);
    for (int i = 0; i < 4; i++) drive(1, 1, 3, 70, 75);
    wait_state("reverse_cool", ST_COOL, 3);

    // Range boundaries
    do_reset();
    drive(1, 1, 3, 1, 0);
    drive(1, 1, 3, 1, 0);
    check("b_low_noheat", int'(heating), 0);
    do_reset();
    drive(1, 1, 3, 254, 255);
    drive(1, 1, 3, 254, 255);
    check("b_high_nocool", int'(cooling), 0);
    do_reset();
    drive(1, 1, 3, 250, 253);
    check("b_cool_on", int'(cooling), 1);
    do_reset();
    drive(1, 1, 3, 250, 252);
    check("b_idle", int'(state), ST_IDLE);

    // Mode OFF override, reset mid-COOL, HEAT-only ignores cool demand
    do_reset();
    drive(1, 0, 3, 70, 60);
    drive(1, 1, 3, 70, 60);
    drive(1, 0, 0, 70, 60);
    check("off_lock", int'(state), ST_LOCK);
    check("off_heat", int'(heating), 0);
    do_reset();
    drive(1, 0, 3, 70, 80);
    check("cool_active", int'(cooling), 1);
    drive(0, 0, 3, 70, 80);
    check("rst_cool", int'(cooling), 0);
    check("rst_fan", int'(fan), 0);
    check("rst_idle", int'(state), ST_IDLE);
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, 1, 1, 70, 80);
    check("heatonly_nocool", int'(cooling), 0);

    // Heat cycle end observes fan behaviour in LOCKOUT
    do_reset();
    drive(1, 0, 3, 70, 60);
    for (int i = 0; i < 5; i++) drive(1, 1, 3, 70, 72);
    for (int i = 0; i < 5; i++) drive(1, 1, 3, 70, 72);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      int sp, ind, md;
      md = int'(mode);
      sp = int'(user_temp_setting);
      if ($urandom_range(0, 31) == 0) md = int'($urandom_range(0, 3));
      if ($urandom_range(0, 63) == 0) begin
        case ($urandom_range(0, 3))
          0: sp = 0;
          1: sp = 255;
          default: sp = int'($urandom_range(0, 255));
        endcase
      end
      ind = int'(indoor_temp);
      if ($urandom_range(0, 3) == 0) ind = sp + int'($urandom_range(0, 12)) - 6;
      if (ind < 0) ind = 0;
      if (ind > 255) ind = 255;
      drive(($urandom_range(0, 99) < 2) ? 0 : 1, int'($urandom_range(0, 1)), md, sp, ind);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
